// File: rtl/uart_rxfsm.sv
// UART receive state machine running from a 16x baud clock.
// Synchronizes the serial input, frames start/data/parity/stop bits with
// 2-of-3 majority sampling at mid-bit, and reports each received byte to
// the RX FIFO together with single-cycle status pulses.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for a falling edge on the synchronized input
//   START  | qualifying the start bit; a high majority is a glitch
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | checking the parity bit against the received byte
//   STOP1  | first stop bit: byte handoff, framing and parity reporting
//   STOP2  | optional second stop bit: framing check only
module uart_rxfsm (
  input  logic       reset_n,
  input  logic       baud_clk_16x,
  input  logic       cfg_rx_enable,
  input  logic       cfg_stop_bit,
  input  logic [1:0] cfg_pri_mod,
  input  logic       fifo_full,
  output logic       fifo_wr,
  output logic [7:0] fifo_data,
  output logic       frm_err,
  output logic       par_err,
  output logic       overrun,
  input  logic       si
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic       si_meta_q, si_meta_d;
  logic       si_s_q, si_s_d;
  logic       si_d_q, si_d_d;
  logic [3:0] divcnt_q, divcnt_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rxdata_q, rxdata_d;
  logic       perr_q, perr_d;
  logic       smp7_q, smp7_d;
  logic       smp8_q, smp8_d;
  logic [7:0] fifo_data_q, fifo_data_d;
  logic       fifo_wr_q, fifo_wr_d;
  logic       frm_err_q, frm_err_d;
  logic       par_err_q, par_err_d;
  logic       overrun_q, overrun_d;

  logic       maj;
  logic       mid_bit;
  logic       end_bit;
  logic       par_exp;

  // Majority of the three mid-bit samples; only meaningful when divcnt is 9,
  // where the third sample is the live synchronized input.
  assign maj     = (smp7_q & smp8_q) | (smp7_q & si_s_q) | (smp8_q & si_s_q);
  assign mid_bit = (divcnt_q == 4'd9);
  assign end_bit = (divcnt_q == 4'd15);
  assign par_exp = cfg_pri_mod[0] ? ~^rxdata_q : ^rxdata_q;

  // Next-state, datapath and output-pulse logic.
  always_comb begin
    state_d     = state_q;
    si_meta_d   = si;
    si_s_d      = si_meta_q;
    si_d_d      = si_s_q;
    divcnt_d    = (state_q == IDLE) ? 4'd0 : divcnt_q + 4'd1;
    cnt_d       = cnt_q;
    rxdata_d    = rxdata_q;
    perr_d      = perr_q;
    smp7_d      = (divcnt_q == 4'd7) ? si_s_q : smp7_q;
    smp8_d      = (divcnt_q == 4'd8) ? si_s_q : smp8_q;
    fifo_data_d = fifo_data_q;
    fifo_wr_d   = 1'b0;
    frm_err_d   = 1'b0;
    par_err_d   = 1'b0;
    overrun_d   = 1'b0;

    if (!cfg_rx_enable) begin
      state_d  = IDLE;
      divcnt_d = 4'd0;
      cnt_d    = 3'd0;
      rxdata_d = 8'h00;
      perr_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Edge-qualified so a line stuck low after a break is not re-framed.
          if (si_d_q && !si_s_q) begin
            state_d  = START;
            divcnt_d = 4'd0;
            perr_d   = 1'b0;
          end
        end
        START: begin
          if (mid_bit && maj) begin
            state_d  = IDLE;
            divcnt_d = 4'd0;
          end else if (end_bit) begin
            state_d = DATA;
            cnt_d   = 3'd0;
          end
        end
        DATA: begin
          if (mid_bit) rxdata_d[cnt_q] = maj;
          if (end_bit) begin
            if (cnt_q == 3'd7) state_d = cfg_pri_mod[1] ? PARITY : STOP1;
            else cnt_d = cnt_q + 3'd1;
          end
        end
        PARITY: begin
          if (mid_bit) perr_d = (maj != par_exp);
          if (end_bit) state_d = STOP1;
        end
        STOP1: begin
          if (mid_bit) begin
            fifo_data_d = rxdata_q;
            fifo_wr_d   = !fifo_full;
            overrun_d   = fifo_full;
            par_err_d   = perr_q;
            frm_err_d   = !maj;
            // Leaving at mid stop bit lets the next start edge be caught early.
            if (!cfg_stop_bit) begin
              state_d  = IDLE;
              divcnt_d = 4'd0;
            end
          end else if (end_bit) begin
            state_d = STOP2;
          end
        end
        STOP2: begin
          if (mid_bit) begin
            frm_err_d = !maj;
            state_d   = IDLE;
            divcnt_d  = 4'd0;
          end
        end
        default: begin
          state_d  = IDLE;
          divcnt_d = 4'd0;
        end
      endcase
    end
  end

  // State, synchronizer and output registers with asynchronous reset.
  always_ff @(posedge baud_clk_16x or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      si_meta_q   <= 1'b1;
      si_s_q      <= 1'b1;
      si_d_q      <= 1'b1;
      divcnt_q    <= 4'd0;
      cnt_q       <= 3'd0;
      rxdata_q    <= 8'h00;
      perr_q      <= 1'b0;
      smp7_q      <= 1'b1;
      smp8_q      <= 1'b1;
      fifo_data_q <= 8'h00;
      fifo_wr_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      par_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      si_meta_q   <= si_meta_d;
      si_s_q      <= si_s_d;
      si_d_q      <= si_d_d;
      divcnt_q    <= divcnt_d;
      cnt_q       <= cnt_d;
      rxdata_q    <= rxdata_d;
      perr_q      <= perr_d;
      smp7_q      <= smp7_d;
      smp8_q      <= smp8_d;
      fifo_data_q <= fifo_data_d;
      fifo_wr_q   <= fifo_wr_d;
      frm_err_q   <= frm_err_d;
      par_err_q   <= par_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign fifo_wr   = fifo_wr_q;
  assign fifo_data = fifo_data_q;
  assign frm_err   = frm_err_q;
  assign par_err   = par_err_q;
  assign overrun   = overrun_q;

endmodule
